ipbb_rdy_pipe: RTL and testbench

// - N-stage valid/ready pipeline. Delays a W-bit word by N cycles like the fixed pipe, and also

---
 rtl/ipbb_rdy_pipe.sv | 101 ++++++++++
 tb/tb_ipbb_rdy_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipbb_rdy_pipe.sv
// ipbb_rdy_pipe: N-stage valid/ready pipeline built from 2-entry skid slices.
// Forward valid/data and backward ready are both registered at every stage,
// so long routes can be retimed without losing or duplicating words.
module ipbb_rdy_pipe #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    input  logic                       out_ready,
    output logic [$clog2(2*N+1)-1:0]   occ
);

    localparam int unsigned OccW = $clog2(2*N+1);

    logic [N-1:0]    w_main_v;
    logic [N-1:0]    w_skid_v;
    logic [W-1:0]    w_main_d [N];
    logic [OccW-1:0] r_occ;
    logic            w_in_x;
    logic            w_out_x;

    // rst gates in_ready so upstream never sees a stale ready while the slices clear.
    assign in_ready  = !rst && !w_skid_v[0];
    assign out_valid = w_main_v[N-1];
    assign out_data  = w_main_d[N-1];
    assign occ       = r_occ;
    assign w_in_x    = in_valid && in_ready;
    assign w_out_x   = out_valid && out_ready;

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic         r_main_v;
        logic         r_skid_v;
        logic [W-1:0] r_main_d;
        logic [W-1:0] r_skid_d;
        logic         w_up_x;
        logic [W-1:0] w_up_d;
        logic         w_dn_rdy;
        logic         w_load;

        if (k == 0) begin : g_first
            assign w_up_x = w_in_x;
            assign w_up_d = in_data;
        end else begin : g_mid
            assign w_up_x = w_main_v[k-1] && !r_skid_v;
            assign w_up_d = w_main_d[k-1];
        end

        if (k == N - 1) begin : g_last
            assign w_dn_rdy = out_ready;
        end else begin : g_inner
            assign w_dn_rdy = !w_skid_v[k+1];
        end

        // Main register is free when empty or being drained this cycle.
        assign w_load = !r_main_v || w_dn_rdy;

        assign w_main_v[k] = r_main_v;
        assign w_skid_v[k] = r_skid_v;
        assign w_main_d[k] = r_main_d;

        // Slice occupancy flags: refill main from skid first, else park new word in skid.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (w_load) begin
                r_main_v <= r_skid_v || w_up_x;
                r_skid_v <= 1'b0;
            end else if (w_up_x) begin
                r_skid_v <= 1'b1;
            end
        end

        // Slice data registers follow the flag moves; no reset needed on data.
        always_ff @(posedge clk) begin
            if (w_load) begin
                r_main_d <= r_skid_v ? r_skid_d : w_up_d;
            end else if (w_up_x) begin
                r_skid_d <= w_up_d;
            end
        end
    end

    // Word count: +1 per accepted input, -1 per delivered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_in_x && !w_out_x) begin
            r_occ <= r_occ + OccW'(1);
        end else if (!w_in_x && w_out_x) begin
            r_occ <= r_occ - OccW'(1);
        end
    end

endmodule

// File: tb/tb_ipbb_rdy_pipe.sv
// Bench for ipbb_rdy_pipe: three instances (N=2, N=1, N=8, W=8) checked against
// queue-based expectations for order, latency, capacity, occupancy and reset.
module tb_ipbb_rdy_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [3];
    logic [7:0] in_data   [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic [7:0] out_data  [3];
    logic       out_ready [3];
    logic [2:0] occ_n2;
    logic [1:0] occ_n1;
    logic [4:0] occ_n8;
    int         occ_v [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        occ_v[0] = int'(occ_n2);
        occ_v[1] = int'(occ_n1);
        occ_v[2] = int'(occ_n8);
    end

    ipbb_rdy_pipe #(.W(8), .N(2)) u_n2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
        .occ(occ_n2)
    );

    ipbb_rdy_pipe #(.W(8), .N(1)) u_n1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
        .occ(occ_n1)
    );

    ipbb_rdy_pipe #(.W(8), .N(8)) u_n8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
        .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready[2]),
        .occ(occ_n8)
    );

    function automatic int depth(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = 8'h00;
            out_ready[i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 8'h55;
        end
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (out_valid[d] !== 1'b0 || occ_v[d] !== 0 || in_ready[d] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_hold N=%0d: out_valid=%b occ=%0d in_ready=%b, want 0/0/0",
                             depth(d), out_valid[d], occ_v[d], in_ready[d]);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || occ_v[d] !== 0) begin
                bad++;
                $display("FAIL reset_release N=%0d: in_ready=%b out_valid=%b occ=%0d, want 1/0/0",
                         depth(d), in_ready[d], out_valid[d], occ_v[d]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_streaming(input int d);
        int n;
        int exp_q[$];
        int t_q[$];
        int sent;
        int got;
        int first_out;
        int last_out;
        n = depth(d);
        sent = 0;
        got = 0;
        first_out = -1;
        last_out = -1;
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b1;
        in_data[d]   = 8'h01;
        for (int c = 0; c < 16 + n + 20 && got < 16; c++) begin
            @(negedge clk);
            total++;
            if (occ_v[d] > n) begin
                bad++;
                $display("FAIL stream_occ N=%0d: occ=%0d, want <= %0d", n, occ_v[d], n);
            end
            if (out_valid[d]) begin
                total++;
                if (exp_q.size() == 0 || out_data[d] !== 8'(exp_q[0])) begin
                    bad++;
                    $display("FAIL stream_data N=%0d: got %h, want %h", n, out_data[d],
                             exp_q.size() > 0 ? exp_q[0] : -1);
                end
                if (exp_q.size() > 0) begin
                    total++;
                    if (cyc - t_q[0] != n) begin
                        bad++;
                        $display("FAIL stream_latency N=%0d: got %0d cycles, want %0d",
                                 n, cyc - t_q[0], n);
                    end
                    void'(exp_q.pop_front());
                    void'(t_q.pop_front());
                end
                got++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_valid[d] && in_ready[d]) begin
                exp_q.push_back(sent + 1);
                t_q.push_back(cyc);
                sent++;
            end
            @(posedge clk); #1;
            in_valid[d] = (sent < 16);
            in_data[d]  = 8'(sent + 1);
        end
        in_valid[d] = 1'b0;
        total++;
        if (got != 16 || last_out - first_out != 15) begin
            bad++;
            $display("FAIL stream_count N=%0d: got %0d words over span %0d, want 16 over 15",
                     n, got, last_out - first_out);
        end
    endtask

    task automatic test_stall(input int d);
        int n;
        int acc;
        int got;
        int gap;
        bit started;
        n = depth(d);
        acc = 0;
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b1;
        in_data[d]   = 8'hA0;
        for (int c = 0; c < 3 * n + 4; c++) begin
            @(negedge clk);
            if (in_valid[d] && in_ready[d]) acc++;
            @(posedge clk); #1;
            in_data[d] = 8'(160 + acc);
        end
        in_valid[d] = 1'b0;
        @(negedge clk);
        total++;
        if (acc != 2 * n || in_ready[d] !== 1'b0 || occ_v[d] != 2 * n || out_valid[d] !== 1'b1) begin
            bad++;
            $display("FAIL stall_fill N=%0d: acc=%0d in_ready=%b occ=%0d out_valid=%b, want %0d/0/%0d/1",
                     n, acc, in_ready[d], occ_v[d], out_valid[d], 2 * n, 2 * n);
        end
        @(posedge clk); #1;
        out_ready[d] = 1'b1;
        got = 0;
        gap = 0;
        started = 1'b0;
        for (int c = 0; c < 3 * n + 10 && got < 2 * n; c++) begin
            @(negedge clk);
            if (out_valid[d]) begin
                total++;
                if (out_data[d] !== 8'(160 + got)) begin
                    bad++;
                    $display("FAIL stall_data N=%0d: got %h, want %h", n, out_data[d], 8'(160 + got));
                end
                got++;
                started = 1'b1;
            end else if (started) begin
                gap++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (got != 2 * n || gap != 0 || occ_v[d] != 0 || out_valid[d] !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain N=%0d: got=%0d gaps=%0d occ=%0d out_valid=%b, want %0d/0/0/0",
                     n, got, gap, occ_v[d], out_valid[d], 2 * n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int d);
        int n;
        int q[$];
        bit prev_stall;
        n = depth(d);
        prev_stall = 1'b0;
        for (int c = 0; c < 10040; c++) begin
            if (c < 10000) begin
                in_valid[d]  = ($urandom_range(0, 1) == 1);
                in_data[d]   = 8'($urandom);
                out_ready[d] = ($urandom_range(0, 1) == 1);
            end else begin
                in_valid[d]  = 1'b0;
                out_ready[d] = 1'b1;
            end
            @(negedge clk);
            total++;
            if (occ_v[d] != q.size() || occ_v[d] > 2 * n) begin
                bad++;
                $display("FAIL rand_occ c=%0d: occ=%0d, want %0d (max %0d)", c, occ_v[d], q.size(), 2 * n);
            end
            if (prev_stall) begin
                total++;
                if (out_valid[d] !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_hold c=%0d: out_valid=%b, want 1", c, out_valid[d]);
                end
            end
            if (q.size() == 0) begin
                total++;
                if (out_valid[d] !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_empty c=%0d: out_valid=%b, want 0", c, out_valid[d]);
                end
                total++;
                if (in_ready[d] !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_ready c=%0d: in_ready=%b, want 1", c, in_ready[d]);
                end
            end else if (out_valid[d]) begin
                total++;
                if (out_data[d] !== 8'(q[0])) begin
                    bad++;
                    $display("FAIL rand_data c=%0d: got %h, want %h", c, out_data[d], 8'(q[0]));
                end
            end
            if (out_valid[d] && out_ready[d] && q.size() > 0) void'(q.pop_front());
            if (in_valid[d] && in_ready[d]) q.push_back(int'(in_data[d]));
            prev_stall = out_valid[d] && !out_ready[d];
            @(posedge clk); #1;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL rand_drain: %0d words left in model, want 0", q.size());
        end
    endtask

    task automatic test_reset_mid_stall(input int d);
        int acc;
        int seen;
        acc = 0;
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b1;
        in_data[d]   = 8'hC0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_valid[d] && in_ready[d]) acc++;
            @(posedge clk); #1;
            in_data[d] = 8'(192 + acc);
        end
        @(negedge clk);
        total++;
        if (acc != 4 || occ_v[d] != 4) begin
            bad++;
            $display("FAIL midrst_fill: acc=%0d occ=%0d, want 4/4", acc, occ_v[d]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid[d] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        total++;
        if (occ_v[d] != 0 || out_valid[d] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear: occ=%0d out_valid=%b, want 0/0", occ_v[d], out_valid[d]);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid[d]) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst_ghost: %0d words emitted after reset, want 0", seen);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        rst = 1'b1;
        test_reset();
        for (int d = 0; d < 3; d++) begin
            test_streaming(d);
            test_stall(d);
        end
        test_random(0);
        test_reset_mid_stall(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
